debouncer_fsm: RTL and testbench

DEBOUNCER_FSM -- requirements
Module: debouncer_fsm

---
 rtl/debouncer_fsm_if.sv | 18 +
 rtl/debouncer_fsm.sv | 108 ++++++++++
 tb/tb_debouncer_fsm.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/debouncer_fsm_if.sv
// Pushbutton debouncer signal bundle; btn_release exists only with DEBOUNCE_RELEASE_PULSE_EN.
interface debouncer_fsm_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   btn_in;
  logic                   btn_level;
  logic                   btn_pulse;
  logic [COUNT_WIDTH-1:0] press_count;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic                   btn_release;

  modport master (output btn_in, input btn_level, input btn_pulse, input press_count, input btn_release);
  modport slave  (input btn_in, output btn_level, output btn_pulse, output press_count, output btn_release);
`else
  modport master (output btn_in, input btn_level, input btn_pulse, input press_count);
  modport slave  (input btn_in, output btn_level, output btn_pulse, output press_count);
`endif
endinterface

// File: rtl/debouncer_fsm.sv
// Pushbutton debouncer: 2-flop sync + 4-state qualify FSM; press strobe STABLE_CYCLES+3 edges after input rises.
// Optional DEBOUNCE_RELEASE_PULSE_EN adds a one-cycle btn_release strobe on each accepted release.
module debouncer_fsm #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic           clock,
  input  logic           reset,
  debouncer_fsm_if.slave btn
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHK_PRESS, HELD, CHK_RELEASE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sync1, sync2;
  logic                   level_q, pulse_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   press_hit, release_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_hit   = 1'b0;
    release_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2) begin
          state_d = CHK_PRESS;
          cnt_d   = '0;
        end
      end
      CHK_PRESS: begin
        if (!sync2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TERM) begin
          state_d   = HELD;
          cnt_d     = '0;
          press_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!sync2) begin
          state_d = CHK_RELEASE;
          cnt_d   = '0;
        end
      end
      CHK_RELEASE: begin
        if (sync2) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == TERM) begin
          state_d     = IDLE;
          cnt_d       = '0;
          release_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync1   <= btn.btn_in;
      sync2   <= sync1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= (state_d == HELD) || (state_d == CHK_RELEASE);
      pulse_q <= press_hit;
      if (press_hit) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_pulse   = pulse_q;
  assign btn.press_count = count_q;

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic release_q;
  always_ff @(posedge clock) begin
    if (reset) release_q <= 1'b0;
    else       release_q <= release_hit;
  end
  assign btn.btn_release = release_q;
`else
  logic unused_release;
  assign unused_release = release_hit;
`endif
endmodule

// File: tb/tb_debouncer_fsm.sv
// Bench for debouncer_fsm: run-length reference model checked every cycle plus directed literal checks.
module tb_debouncer_fsm;
  localparam int S  = 4;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic cmp_en = 1'b0;
  int   pulse_total = 0;
  int   rel_total = 0;

  debouncer_fsm_if #(.COUNT_WIDTH(CW)) bus ();

  debouncer_fsm #(.STABLE_CYCLES(S), .COUNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .btn   (bus)
  );

  always #5 clock = ~clock;

  // Reference: the input is seen two edges late; the level flips once the delayed
  // input has disagreed with it for S+1 consecutive edges.
  logic          m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_pulse = 1'b0, m_rel = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  int            m_run = 0;

  always @(posedge clock) begin
    logic v, ln, pn, rn_rel;
    logic [CW-1:0] cn;
    int rn;
    if (reset) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0; m_pulse <= 1'b0;
      m_rel <= 1'b0; m_cnt <= '0; m_run <= 0;
    end else begin
      v = m_s2; ln = m_level; rn = m_run; cn = m_cnt; pn = 1'b0; rn_rel = 1'b0;
      if (v !== ln) begin
        rn = rn + 1;
        if (rn == S + 1) begin
          ln = v;
          rn = 0;
          if (v) begin pn = 1'b1; cn = cn + 1'b1; end
          else rn_rel = 1'b1;
        end
      end else begin
        rn = 0;
      end
      m_s2 <= m_s1; m_s1 <= bus.btn_in;
      m_level <= ln; m_run <= rn; m_cnt <= cn; m_pulse <= pn; m_rel <= rn_rel;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (bus.btn_pulse === 1'b1) pulse_total++;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    if (bus.btn_release === 1'b1) rel_total++;
`endif
    if (cmp_en) begin
      chk("model_level", {31'd0, bus.btn_level}, {31'd0, m_level});
      chk("model_pulse", {31'd0, bus.btn_pulse}, {31'd0, m_pulse});
      chk("model_count", {28'd0, bus.press_count}, {28'd0, m_cnt});
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      chk("model_release", {31'd0, bus.btn_release}, {31'd0, m_rel});
`endif
    end
  end

  task automatic step(input logic b, input logic r);
    bus.btn_in = b;
    reset = r;
    @(posedge clock);
    #1;
  endtask

  task automatic press_release(input int hold, input int rel);
    for (int i = 0; i < hold; i++) step(1'b1, 1'b0);
    for (int i = 0; i < rel; i++) step(1'b0, 1'b0);
  endtask

  int p0, r0;
  logic [4:0] bounce;

  initial begin
    bus.btn_in = 1'b0;
    reset = 1'b1;
    step(1'b0, 1'b1);
    cmp_en = 1'b1;
    step(1'b0, 1'b1);
    chk("reset_level", {31'd0, bus.btn_level}, 0);
    chk("reset_pulse", {31'd0, bus.btn_pulse}, 0);
    chk("reset_count", {28'd0, bus.press_count}, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Clean press: edge i is the i-th sample of btn_in=1.
    p0 = pulse_total;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) chk("press_pulse_e5", {31'd0, bus.btn_pulse}, 0);
      if (i == 5) chk("press_level_e5", {31'd0, bus.btn_level}, 0);
      if (i == 6) chk("press_pulse_e6", {31'd0, bus.btn_pulse}, 1);
      if (i == 6) chk("press_level_e6", {31'd0, bus.btn_level}, 1);
      if (i == 7) chk("press_pulse_e7", {31'd0, bus.btn_pulse}, 0);
    end
    chk("press_count", {28'd0, bus.press_count}, 1);
    chk("press_pulses", pulse_total - p0, 1);
    r0 = rel_total;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (i == 5) chk("rel_level_e5", {31'd0, bus.btn_level}, 1);
      if (i == 6) chk("rel_level_e6", {31'd0, bus.btn_level}, 0);
    end
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    chk("rel_pulses", rel_total - r0, 1);
`endif

    // Bounce pattern 1,0,1,1,0 then steady low.
    p0 = pulse_total;
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) step(bounce[i], 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("bounce_pulses", pulse_total - p0, 0);
    chk("bounce_level", {31'd0, bus.btn_level}, 0);
    chk("bounce_count", {28'd0, bus.press_count}, 1);

    // Release glitch while held, then a real release.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    r0 = rel_total;
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    chk("glitch_level", {31'd0, bus.btn_level}, 1);
    chk("glitch_count", {28'd0, bus.press_count}, 2);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    chk("glitch_rel", rel_total - r0, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (i == 5) chk("grel_level_e5", {31'd0, bus.btn_level}, 1);
      if (i == 6) chk("grel_level_e6", {31'd0, bus.btn_level}, 0);
    end
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    chk("grel_pulses", rel_total - r0, 1);
`endif

    // Reset at edge 4 of a press; button stays held afterwards.
    p0 = pulse_total;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_mid_count", {28'd0, bus.press_count}, 0);
    chk("rst_mid_pulses", pulse_total - p0, 0);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b0);
      if (j == 5) chk("rst_pulse_e5", {31'd0, bus.btn_pulse}, 0);
      if (j == 6) chk("rst_pulse_e6", {31'd0, bus.btn_pulse}, 1);
    end
    chk("rst_count_after", {28'd0, bus.press_count}, 1);

    // Reset while held.
    step(1'b1, 1'b1);
    chk("rst_hold_level", {31'd0, bus.btn_level}, 0);
    chk("rst_hold_count", {28'd0, bus.press_count}, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // Input drops exactly on the terminal-count edge vs one edge later.
    p0 = pulse_total;
    press_release(4, 10);
    chk("term_drop_pulses", pulse_total - p0, 0);
    press_release(5, 10);
    chk("term_hold_pulses", pulse_total - p0, 1);
    chk("term_hold_count", {28'd0, bus.press_count}, 1);

    // Wrap: 16 more presses take the 4-bit counter from 1 round to 1.
    p0 = pulse_total;
    for (int k = 0; k < 15; k++) press_release(10, 10);
    chk("wrap_count_15", {28'd0, bus.press_count}, 0);
    press_release(10, 10);
    chk("wrap_count_16", {28'd0, bus.press_count}, 1);
    chk("wrap_pulses", pulse_total - p0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
